// File: rtl/mpu_encoder_if.sv
// ---------------------------------------------------------------------------
// mpu_encoder_if
// Groups the field-input handshake and the byte-output stream of the MPU
// instruction encoder.
//   in_valid/in_ready      : instruction-field handshake (source -> encoder)
//   in_op, in_size         : opcode and operand size class
//   in_idx0..3, in_s0..3   : register indices and per-operand selectors
//   in_imm, in_addr        : LOAD immediate, JMP target
//   out_valid/out_ready    : byte stream handshake (encoder -> sink)
//   out_data, out_last     : encoded byte and end-of-instruction marker
//   isize                  : byte length of the instruction being emitted
//   err                    : one-cycle pulse on an unsupported opcode
// The master modport is the side that supplies fields and sinks bytes; the
// slave modport is the encoder itself.
// ---------------------------------------------------------------------------
interface mpu_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [1:0]  in_size;
  logic [4:0]  in_idx0;
  logic [4:0]  in_idx1;
  logic [4:0]  in_idx2;
  logic [4:0]  in_idx3;
  logic [2:0]  in_s0;
  logic [2:0]  in_s1;
  logic [2:0]  in_s2;
  logic [2:0]  in_s3;
  logic [63:0] in_imm;
  logic [15:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  isize;
  logic        err;

  modport master (
    output in_valid, in_op, in_size,
    output in_idx0, in_idx1, in_idx2, in_idx3,
    output in_s0, in_s1, in_s2, in_s3,
    output in_imm, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_last, isize, err
  );

  modport slave (
    input  in_valid, in_op, in_size,
    input  in_idx0, in_idx1, in_idx2, in_idx3,
    input  in_s0, in_s1, in_s2, in_s3,
    input  in_imm, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_last, isize, err
  );
endinterface

// File: rtl/mpu_encoder.sv
// ---------------------------------------------------------------------------
// mpu_encoder
// Serialises one MPU instruction into a byte stream. Fields are captured on
// the in_valid/in_ready handshake, then bytes are emitted one per accepted
// out_valid/out_ready beat, LSB-first for multi-byte immediates/addresses.
// Ports:
//   sys_clk : single clock, rising edge
//   sys_rst : asynchronous, active-low reset
//   bus     : mpu_encoder_if.slave (field input, byte output, isize, err)
// Layouts (byte0 = {op, 2'b00, size}, operand k = {idxk, sk}):
//   MASK/CMP: byte0 + operands 0..3         (5 bytes)
//   LT      : byte0 + operands 0..2         (4 bytes)
//   MLOAD   : byte0 + operand 0             (2 bytes)
//   LOAD    : byte0 + operand 0 + 1<<size immediate bytes (3/4/6/10)
//   JMP     : byte0 + addr[7:0] + addr[15:8] (3 bytes)
// ---------------------------------------------------------------------------
module mpu_encoder (
  input  logic         sys_clk,
  input  logic         sys_rst,
  mpu_encoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [3:0] OP_MASK  = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_LT    = 4'h3;
  localparam logic [3:0] OP_MLOAD = 4'hd;
  localparam logic [3:0] OP_LOAD  = 4'he;
  localparam logic [3:0] OP_JMP   = 4'hf;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  isize_q, isize_d;
  logic        err_q, err_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [4:0]  idx_q [4];
  logic [4:0]  idx_d [4];
  logic [2:0]  s_q [4];
  logic [2:0]  s_d [4];
  logic [63:0] imm_q, imm_d;
  logic [15:0] addr_q, addr_d;

  logic        accept;
  logic [3:0]  new_isize;
  logic [7:0]  byte_sel;
  logic [1:0]  opnd_k;
  logic [2:0]  imm_k;

  // Instruction length straight from the incoming fields; zero marks an
  // unsupported opcode, so the same decode also acts as the legality check.
  always_comb begin
    new_isize = 4'd0;
    case (bus.in_op)
      OP_MASK, OP_CMP: new_isize = 4'd5;
      OP_LT:           new_isize = 4'd4;
      OP_MLOAD:        new_isize = 4'd2;
      OP_LOAD:         new_isize = 4'd2 + (4'd1 << bus.in_size);
      OP_JMP:          new_isize = 4'd3;
      default:         new_isize = 4'd0;
    endcase
  end

  assign accept = bus.in_valid && (state_q == IDLE);

  // Next-state process.
  // NOTE: every variable gets its default before the case; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isize_d = isize_q;
    err_d   = 1'b0;
    op_d    = op_q;
    size_d  = size_q;
    idx_d   = idx_q;
    s_d     = s_q;
    imm_d   = imm_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Fields are snapshotted so later input changes cannot reach
          // bytes already in flight.
          op_d     = bus.in_op;
          size_d   = bus.in_size;
          idx_d[0] = bus.in_idx0;
          idx_d[1] = bus.in_idx1;
          idx_d[2] = bus.in_idx2;
          idx_d[3] = bus.in_idx3;
          s_d[0]   = bus.in_s0;
          s_d[1]   = bus.in_s1;
          s_d[2]   = bus.in_s2;
          s_d[3]   = bus.in_s3;
          imm_d    = bus.in_imm;
          addr_d   = bus.in_addr;
          if (new_isize != 4'd0) begin
            state_d = EMIT;
            cnt_d   = 4'd0;
            isize_d = new_isize;
          end else begin
            // Unsupported opcode: stay idle, keep the previous isize.
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (cnt_q == isize_q - 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      isize_q <= 4'd0;
      err_q   <= 1'b0;
      op_q    <= 4'd0;
      size_q  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        idx_q[i] <= 5'd0;
        s_q[i]   <= 3'd0;
      end
      imm_q   <= 64'd0;
      addr_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isize_q <= isize_d;
      err_q   <= err_d;
      op_q    <= op_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
    end
  end

  // Byte position -> operand / immediate slot. Byte 1 is operand 0; for
  // LOAD, byte 2 onward is the immediate, LSB first.
  assign opnd_k = 2'(cnt_q - 4'd1);
  assign imm_k  = 3'(cnt_q - 4'd2);

  always_comb begin
    byte_sel = 8'h00;
    if (cnt_q == 4'd0) begin
      byte_sel = {op_q, 2'b00, size_q};
    end else if (op_q == OP_JMP) begin
      byte_sel = (cnt_q == 4'd1) ? addr_q[7:0] : addr_q[15:8];
    end else if (op_q == OP_LOAD && cnt_q >= 4'd2) begin
      byte_sel = imm_q[{imm_k, 3'b000} +: 8];
    end else begin
      byte_sel = {idx_q[opnd_k], s_q[opnd_k]};
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = (state_q == EMIT) ? byte_sel : 8'h00;
  assign bus.out_last  = (state_q == EMIT) && (cnt_q == isize_q - 4'd1);
  assign bus.isize     = isize_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mpu_encoder.sv
// ---------------------------------------------------------------------------
// tb_mpu_encoder
// Directed bench for mpu_encoder: a table of instructions with hand-encoded
// byte streams, plus hand-written sequences for output stalls, an
// unsupported opcode and reset in the middle of an instruction.
// ---------------------------------------------------------------------------
module tb_mpu_encoder;

  logic sys_clk;
  logic sys_rst;

  mpu_encoder_if bus ();

  mpu_encoder dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  size;
    logic [19:0] idx;    // {idx3, idx2, idx1, idx0}
    logic [11:0] sel;    // {s3, s2, s1, s0}
    logic [63:0] imm;
    logic [15:0] addr;
    int          n;      // expected isize / byte count
    logic [79:0] bytes;  // expected byte k at [8k +: 8]
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] last_isize;
  vec_t vecs [5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an instruction on the field inputs; caller is at a negedge.
  task automatic drive(input vec_t v);
    bus.in_op    = v.op;
    bus.in_size  = v.size;
    bus.in_idx0  = v.idx[4:0];
    bus.in_idx1  = v.idx[9:5];
    bus.in_idx2  = v.idx[14:10];
    bus.in_idx3  = v.idx[19:15];
    bus.in_s0    = v.sel[2:0];
    bus.in_s1    = v.sel[5:3];
    bus.in_s2    = v.sel[8:6];
    bus.in_s3    = v.sel[11:9];
    bus.in_imm   = v.imm;
    bus.in_addr  = v.addr;
    bus.in_valid = 1'b1;
  endtask

  // Overwrite the fields after acceptance; bytes in flight must not change.
  task automatic scramble();
    bus.in_valid = 1'b0;
    bus.in_op    = 4'h1;
    bus.in_size  = 2'd3;
    bus.in_idx0  = 5'h1f;
    bus.in_idx1  = 5'h1f;
    bus.in_idx2  = 5'h1f;
    bus.in_idx3  = 5'h1f;
    bus.in_s0    = 3'h7;
    bus.in_s1    = 3'h7;
    bus.in_s2    = 3'h7;
    bus.in_s3    = 3'h7;
    bus.in_imm   = '1;
    bus.in_addr  = 16'hffff;
  endtask

  // Full instruction with out_ready held high: one byte per cycle, last
  // byte handshaken isize cycles after acceptance, then back to idle.
  task automatic run_vec(input vec_t v);
    bus.out_ready = 1'b1;
    check({v.name, " in_ready before accept"}, 80'(bus.in_ready), 80'(1));
    drive(v);
    @(negedge sys_clk);
    scramble();
    check({v.name, " isize"}, 80'(bus.isize), 80'(v.n));
    for (int k = 0; k < v.n; k++) begin
      check($sformatf("%s out_valid[%0d]", v.name, k), 80'(bus.out_valid), 80'(1));
      check($sformatf("%s out_data[%0d]", v.name, k), 80'(bus.out_data), 80'(v.bytes[8*k +: 8]));
      check($sformatf("%s out_last[%0d]", v.name, k), 80'(bus.out_last), 80'(k == v.n - 1));
      check($sformatf("%s in_ready[%0d]", v.name, k), 80'(bus.in_ready), 80'(0));
      @(negedge sys_clk);
    end
    check({v.name, " out_valid after last"}, 80'(bus.out_valid), 80'(0));
    check({v.name, " in_ready after last"}, 80'(bus.in_ready), 80'(1));
    last_isize = 4'(v.n);
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [1:0] size,
                              input logic [19:0] idx, input logic [11:0] sel,
                              input logic [63:0] imm, input logic [15:0] addr,
                              input int n, input logic [79:0] bytes);
    vec_t v;
    v.name = name; v.op = op; v.size = size; v.idx = idx; v.sel = sel;
    v.imm = imm; v.addr = addr; v.n = n; v.bytes = bytes;
    return v;
  endfunction

  initial begin
    vec_t jmp_v, cmp_v, mload_v;
    int   k;
    int   cyc;
    logic rdy;

    // idx/sel = (0,0),(1,1),(2,2),(3,0) -> 0x00,0x09,0x12,0x18
    vecs[0] = mk("MASK", 4'h1, 2'd0, {5'd3, 5'd2, 5'd1, 5'd0}, {3'd0, 3'd2, 3'd1, 3'd0},
                 64'h0, 16'h0, 5, 80'h18_12_09_00_10);
    vecs[1] = mk("LOAD8", 4'he, 2'd0, {5'd0, 5'd0, 5'd0, 5'd1}, {3'd0, 3'd0, 3'd0, 3'd2},
                 64'hff, 16'h0, 3, 80'hff_0a_e0);
    vecs[2] = mk("LOAD64", 4'he, 2'd3, {5'd0, 5'd0, 5'd0, 5'd1}, {3'd0, 3'd0, 3'd0, 3'd2},
                 64'h0123456789abcdef, 16'h0, 10, 80'h01_23_45_67_89_ab_cd_ef_0a_e3);
    // LT size 1: operands (4,5)=0x25, (31,7)=0xff, (16,3)=0x83; operand 3 ignored.
    vecs[3] = mk("LT", 4'h3, 2'd1, {5'd9, 5'd16, 5'd31, 5'd4}, {3'd1, 3'd3, 3'd7, 3'd5},
                 64'h0, 16'h0, 4, 80'h83_ff_25_31);
    vecs[4] = mk("LOAD16", 4'he, 2'd1, {5'd0, 5'd0, 5'd0, 5'd2}, {3'd0, 3'd0, 3'd0, 3'd4},
                 64'hbeef, 16'h0, 4, 80'hbe_ef_14_e1);
    jmp_v   = mk("JMP", 4'hf, 2'd0, 20'h0, 12'h0, 64'h0, 16'h1234, 3, 80'h12_34_f0);
    cmp_v   = mk("CMP", 4'h2, 2'd0, {5'd3, 5'd2, 5'd1, 5'd0}, {3'd0, 3'd2, 3'd1, 3'd0},
                 64'h0, 16'h0, 5, 80'h18_12_09_00_20);
    mload_v = mk("MLOAD", 4'hd, 2'd0, {5'd0, 5'd0, 5'd0, 5'd3}, {3'd0, 3'd0, 3'd0, 3'd1},
                 64'h0, 16'h0, 2, 80'h19_d0);

    // Reset state.
    sys_rst = 1'b0;
    scramble();
    bus.out_ready = 1'b0;
    #12;
    check("rst in_ready", 80'(bus.in_ready), 80'(1));
    check("rst out_valid", 80'(bus.out_valid), 80'(0));
    check("rst out_last", 80'(bus.out_last), 80'(0));
    check("rst out_data", 80'(bus.out_data), 80'(0));
    check("rst isize", 80'(bus.isize), 80'(0));
    check("rst err", 80'(bus.err), 80'(0));
    @(negedge sys_clk);
    sys_rst = 1'b1;

    // Table: first vector is accepted on the first edge after release.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Unsupported opcode: no bytes, one-cycle err, isize kept.
    bus.out_ready = 1'b1;
    drive(mk("BAD", 4'h7, 2'd0, 20'h0, 12'h0, 64'h0, 16'h0, 0, 80'h0));
    @(negedge sys_clk);
    scramble();
    check("bad err pulse", 80'(bus.err), 80'(1));
    check("bad out_valid", 80'(bus.out_valid), 80'(0));
    check("bad in_ready", 80'(bus.in_ready), 80'(1));
    check("bad isize kept", 80'(bus.isize), 80'(last_isize));
    @(negedge sys_clk);
    check("bad err cleared", 80'(bus.err), 80'(0));
    check("bad out_valid later", 80'(bus.out_valid), 80'(0));
    check("bad in_ready later", 80'(bus.in_ready), 80'(1));

    // JMP with out_ready toggling; stalled bytes are rechecked unchanged.
    drive(jmp_v);
    @(negedge sys_clk);
    scramble();
    k = 0;
    cyc = 0;
    rdy = 1'b1;
    while (k < 3 && cyc < 20) begin
      bus.out_ready = rdy;
      check($sformatf("JMP-stall out_valid c%0d", cyc), 80'(bus.out_valid), 80'(1));
      check($sformatf("JMP-stall out_data c%0d", cyc), 80'(bus.out_data), 80'(jmp_v.bytes[8*k +: 8]));
      check($sformatf("JMP-stall out_last c%0d", cyc), 80'(bus.out_last), 80'(k == 2));
      check($sformatf("JMP-stall in_ready c%0d", cyc), 80'(bus.in_ready), 80'(0));
      @(negedge sys_clk);
      if (rdy) k++;
      rdy = ~rdy;
      cyc++;
    end
    check("JMP-stall completed", 80'(k), 80'(3));
    check("JMP-stall in_ready after", 80'(bus.in_ready), 80'(1));
    check("JMP-stall out_valid after", 80'(bus.out_valid), 80'(0));

    // CMP interrupted by reset while byte 2 is presented.
    bus.out_ready = 1'b1;
    drive(cmp_v);
    @(negedge sys_clk);
    scramble();
    for (int j = 0; j < 2; j++) begin
      check($sformatf("CMP out_data[%0d]", j), 80'(bus.out_data), 80'(cmp_v.bytes[8*j +: 8]));
      @(negedge sys_clk);
    end
    check("CMP byte2 presented", 80'(bus.out_data), 80'(8'h09));
    #1 sys_rst = 1'b0;
    #1;
    check("CMP rst out_valid", 80'(bus.out_valid), 80'(0));
    check("CMP rst out_data", 80'(bus.out_data), 80'(0));
    check("CMP rst isize", 80'(bus.isize), 80'(0));
    check("CMP rst in_ready", 80'(bus.in_ready), 80'(1));
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("CMP no resume", 80'(bus.out_valid), 80'(0));

    run_vec(mload_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_encoder.md
MPU_ENCODER -- requirements
Module: mpu_encoder

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 sys_clk  input  1  single clock; all state on rising edge.
REQ-003 sys_rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instruction fields valid.
REQ-005 in_ready  output  1  encoder can accept fields.
REQ-006 in_op  input  4  opcode: 1 MASK, 2 CMP, 3 LT, d MLOAD, e LOAD, f JMP.
REQ-007 in_size  input  2  operand size class, 0=8/1=16/2=32/3=64-bit.
REQ-008 in_idx0..in_idx3  input  5 each  register indices.
REQ-009 in_s0..in_s3  input  3 each  per-operand selector.
REQ-010 in_imm  input  64  LOAD immediate.
REQ-011 in_addr  input  16  JMP target.
REQ-012 out_valid  output  1  out_data holds an instruction byte.
REQ-013 out_ready  input  1  sink accepts byte.
REQ-014 out_data  output  8  encoded byte.
REQ-015 out_last  output  1  final byte of instruction.
REQ-016 isize  output  4  byte length of the instruction being emitted.
REQ-017 err  output  1  one-cycle pulse: unsupported opcode.

Function
REQ-018 Byte 0 SHALL be {in_op, 2'b00, in_size}.
REQ-019 Operand byte k SHALL be {in_idxk, in_sk}.
REQ-020 Instruction layout and isize SHALL be:
  - MASK, CMP: byte0, operands 0..3; isize 5.
  - LT: byte0, operands 0..2; isize 4.
  - MLOAD: byte0, operand 0; isize 2.
  - LOAD: byte0, operand 0, then 1<<in_size immediate bytes, LSB first; isize 3/4/6/10.
  - JMP: byte0, in_addr[7:0], in_addr[15:8]; isize 3.
REQ-021 FSM states SHALL be IDLE and EMIT.
REQ-022 in_ready SHALL be 1 exactly in IDLE.
REQ-023 Acceptance: on in_valid & in_ready, all in_* fields SHALL be latched and isize updated next cycle.
REQ-024 Valid opcode accepted: next state EMIT with byte counter 0.
REQ-025 Unsupported opcode accepted: FSM SHALL stay IDLE, emit no bytes, pulse err for the following cycle, and leave isize unchanged.
REQ-026 In EMIT, out_valid SHALL be 1 and out_data SHALL show the byte at the counter.
REQ-027 out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-028 Each out_valid & out_ready SHALL advance the counter by 1.
REQ-029 out_last SHALL be 1 only while the counter equals isize-1.
REQ-030 Handshake on the out_last byte SHALL return the FSM to IDLE; the next acceptance is possible no earlier than the following cycle, a one-cycle bubble.
REQ-031 Input field changes while in EMIT SHALL not affect bytes in flight.
REQ-032 out_valid SHALL never drop before its byte is accepted.
REQ-033 Byte throughput with out_ready held high SHALL be one byte per cycle; total latency from acceptance to last byte SHALL be isize cycles.
REQ-034 in_size SHALL affect only the LOAD length; for other opcodes it is encoded in byte 0 only.

Reset
REQ-035 sys_rst low SHALL asynchronously force IDLE, out_valid 0, out_last 0, out_data 0, isize 0, err 0, counter 0, latched fields 0.
REQ-036 in_ready SHALL be 1 during and after reset.
REQ-037 Reset mid-EMIT SHALL abandon the instruction; no partial bytes resume after release.
REQ-038 First acceptance SHALL be possible on the first rising edge with sys_rst high.

Verification
REQ-039 The bench SHALL cover the following scenarios:
  - MASK, size 0, idx/s = (0,0),(1,1),(2,2),(3,0), out_ready=1 -> bytes 0x10,0x00,0x09,0x12,0x18; last on byte 5; isize 5.
  - LOAD, size 0, idx0=1, s0=2, imm=0xff -> bytes 0xe0,0x0a,0xff; isize 3. Repeat with size 3, imm=0x0123456789abcdef -> 10 bytes ending 0x01.
  - JMP, addr 0x1234, out_ready toggling 1/0 each cycle -> 0xf0,0x34,0x12, each held stable while stalled; in_ready 0 until after the last byte.
  - Opcode 0x7 -> no out_valid, err high exactly one cycle, in_ready stays 1.
  - Reset asserted after byte 2 of CMP -> out_valid 0 immediately. A subsequent MLOAD idx0=3, s0=1 -> 0xd0,0x19.
